ps2_request_decoder: RTL and testbench

- Front-end stage feeding the elevator datapath request registers.
- Receives PS/2 keyboard frames on ps2c/ps2d and validates start, parity and stop bits.
- Decodes make/break scan codes into single-cycle request strobes: in-cab floor, hall up, hall down, door open, door close.
- Floor requests are one-hot, matching the datapath's n-bit request/LED vectors.

---
 rtl/elevator_pkg.sv | 51 +++++
 rtl/ps2_rx.sv | 130 +++++++++++++
 rtl/ps2_request_decoder.sv | 116 +++++++++++
 tb/tb_ps2_request_decoder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared constants for the elevator PS/2 front end: scan codes, key lookup and
// receiver states.
package elevator_pkg;

  localparam int N_FLOOR_DEF = 6;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_OPEN  = 8'h44;
  localparam logic [7:0] SC_CLOSE = 8'h21;

  // Index i is floor i: '1'..'6', Q..Y, A..H
  localparam logic [5:0][7:0] SC_IN   = {8'h36, 8'h2E, 8'h25, 8'h26, 8'h1E, 8'h16};
  localparam logic [5:0][7:0] SC_UP   = {8'h35, 8'h2C, 8'h2D, 8'h24, 8'h1D, 8'h15};
  localparam logic [5:0][7:0] SC_DOWN = {8'h33, 8'h34, 8'h2B, 8'h23, 8'h1B, 8'h1C};

  typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} rx_state_e;

  typedef enum logic [2:0] {
    KEY_NONE, KEY_IN, KEY_UP, KEY_DOWN, KEY_OPEN, KEY_CLOSE
  } key_kind_e;

  typedef struct packed {
    key_kind_e  kind;
    logic [2:0] floor;
  } key_t;

  function automatic key_t lookup_key(input logic [7:0] code);
    key_t k;
    k.kind  = KEY_NONE;
    k.floor = '0;
    for (int i = 0; i < 6; i++) begin
      if (code == SC_IN[i]) begin
        k.kind  = KEY_IN;
        k.floor = 3'(i);
      end
      if (code == SC_UP[i]) begin
        k.kind  = KEY_UP;
        k.floor = 3'(i);
      end
      if (code == SC_DOWN[i]) begin
        k.kind  = KEY_DOWN;
        k.floor = 3'(i);
      end
    end
    if (code == SC_OPEN)  k.kind = KEY_OPEN;
    if (code == SC_CLOSE) k.kind = KEY_CLOSE;
    return k;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: input synchronisers, ps2c glitch filter, frame FSM and
// inter-edge timeout. Emits one-cycle byte_valid or frame_err per frame.
//
// state | meaning
// IDLE  | waiting for start-bit falling edge
// DATA  | shifting in 8 data bits, LSB first
// PAR   | waiting for the parity bit
// STOP  | waiting for the stop bit; checks parity and stop, then returns to IDLE
module ps2_rx
  import elevator_pkg::*;
#(
  parameter int FILT_LEN    = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FILT_LOAD = FW'(FILT_LEN - 1);
  localparam logic [TW-1:0] TMO_LOAD  = TW'(TIMEOUT_CYC - 1);

  logic          c_s1, c_s2, d_s1, d_s2;
  logic          filt, filt_d;
  logic [FW-1:0] filt_cnt;
  logic          fall;

  rx_state_e     state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      c_s1 <= 1'b1;
      c_s2 <= 1'b1;
      d_s1 <= 1'b1;
      d_s2 <= 1'b1;
    end else begin
      c_s1 <= ps2c;
      c_s2 <= c_s1;
      d_s1 <= ps2d;
      d_s2 <= d_s1;
    end
  end

  // Down-counter runs only while the synchronised clock disagrees with the
  // filtered level; FILT_LEN disagreeing samples in a row flip the output.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      filt     <= 1'b1;
      filt_d   <= 1'b1;
      filt_cnt <= FILT_LOAD;
    end else begin
      filt_d <= filt;
      if (c_s2 == filt) begin
        filt_cnt <= FILT_LOAD;
      end else if (filt_cnt == '0) begin
        filt     <= c_s2;
        filt_cnt <= FILT_LOAD;
      end else begin
        filt_cnt <= filt_cnt - 1'b1;
      end
    end
  end

  assign fall = filt_d & ~filt;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      tmo_cnt    <= TMO_LOAD;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (state == IDLE) begin
        if (fall) begin
          if (!d_s2) begin
            state   <= DATA;
            bit_cnt <= '0;
            tmo_cnt <= TMO_LOAD;
          end else begin
            frame_err <= 1'b1;
          end
        end
      end else if (fall) begin
        tmo_cnt <= TMO_LOAD;
        case (state)
          DATA: begin
            shreg   <= {d_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= PAR;
          end
          PAR: begin
            par_bit <= d_s2;
            state   <= STOP;
          end
          default: begin
            if (d_s2 && (^{shreg, par_bit})) begin
              byte_valid <= 1'b1;
              rx_byte    <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
          end
        endcase
      end else if (tmo_cnt == '0) begin
        frame_err <= 1'b1;
        state     <= IDLE;
      end else begin
        tmo_cnt <= tmo_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_request_decoder.sv
// Turns PS/2 make/break scan codes into one-cycle elevator request strobes.
// Optional typematic-repeat suppression: define TYPEMATIC_FILTER_EN.
module ps2_request_decoder
  import elevator_pkg::*;
#(
  parameter int N_FLOOR     = N_FLOOR_DEF,
  parameter int FILT_LEN    = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic               clk_50M,
  input  logic               rst_n,
  input  logic               ps2c,
  input  logic               ps2d,
  output logic [N_FLOOR-1:0] req_in,
  output logic [N_FLOOR-1:0] req_up,
  output logic [N_FLOOR-1:0] req_down,
  output logic               open_button,
  output logic               close_button,
  output logic               frame_err
);

  logic               byte_valid;
  logic [7:0]         rx_byte;
  logic               ext, brk;
  key_t               key;
  logic               fl_ok;
  logic [N_FLOOR-1:0] onehot;
  logic [N_FLOOR-1:0] in_n, up_n, down_n;
  logic               make_ok;

  ps2_rx #(
    .FILT_LEN    (FILT_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx (
    .clk_50M    (clk_50M),
    .rst_n      (rst_n),
    .ps2c       (ps2c),
    .ps2d       (ps2d),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte),
    .frame_err  (frame_err)
  );

  always_comb begin
    key    = lookup_key(rx_byte);
    fl_ok  = int'(key.floor) < N_FLOOR;
    onehot = {{(N_FLOOR-1){1'b0}}, 1'b1} << key.floor;
    in_n   = (key.kind == KEY_IN && fl_ok) ? onehot : '0;
    up_n   = (key.kind == KEY_UP && fl_ok && int'(key.floor) != N_FLOOR - 1) ? onehot : '0;
    down_n = (key.kind == KEY_DOWN && fl_ok && key.floor != 3'd0) ? onehot : '0;
  end

`ifdef TYPEMATIC_FILTER_EN
  logic       held_vld;
  logic [7:0] held_code;
  logic       held_hit;

  assign held_hit = held_vld && (held_code == rx_byte);
  assign make_ok  = !held_hit;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      held_vld  <= 1'b0;
      held_code <= '0;
    end else if (byte_valid && rx_byte != SC_EXT && rx_byte != SC_BRK && !ext) begin
      if (brk) begin
        if (held_hit) held_vld <= 1'b0;
      end else if (!held_hit) begin
        held_vld  <= 1'b1;
        held_code <= rx_byte;
      end
    end
  end
`else
  assign make_ok = 1'b1;
`endif

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      ext          <= 1'b0;
      brk          <= 1'b0;
      req_in       <= '0;
      req_up       <= '0;
      req_down     <= '0;
      open_button  <= 1'b0;
      close_button <= 1'b0;
    end else begin
      req_in       <= '0;
      req_up       <= '0;
      req_down     <= '0;
      open_button  <= 1'b0;
      close_button <= 1'b0;
      if (frame_err) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (byte_valid) begin
        if (rx_byte == SC_EXT) begin
          ext <= 1'b1;
        end else if (rx_byte == SC_BRK) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (!brk && !ext && make_ok) begin
            req_in       <= in_n;
            req_up       <= up_n;
            req_down     <= down_n;
            open_button  <= (key.kind == KEY_OPEN);
            close_button <= (key.kind == KEY_CLOSE);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_request_decoder.sv
// Directed bench for ps2_request_decoder: bit-banged PS/2 frames, per-output
// pulse counters and hand-computed expectations.
module tb_ps2_request_decoder;

  localparam int NF = 6;
  localparam int FL = 8;
  localparam int LAT = 2 + FL + 2;
`ifdef TYPEMATIC_FILTER_EN
  localparam int TYP_EXP = 2;
`else
  localparam int TYP_EXP = 4;
`endif

  logic          clk_50M = 1'b0;
  logic          rst_n   = 1'b0;
  logic          ps2c    = 1'b1;
  logic          ps2d    = 1'b1;
  logic [NF-1:0] req_in, req_up, req_down;
  logic          open_button, close_button, frame_err;

  ps2_request_decoder #(.N_FLOOR(NF), .FILT_LEN(FL), .TIMEOUT_CYC(50000)) dut (
    .clk_50M      (clk_50M),
    .rst_n        (rst_n),
    .ps2c         (ps2c),
    .ps2d         (ps2d),
    .req_in       (req_in),
    .req_up       (req_up),
    .req_down     (req_down),
    .open_button  (open_button),
    .close_button (close_button),
    .frame_err    (frame_err)
  );

  always #10 clk_50M = ~clk_50M;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_fall = 0;
  int multi = 0;
  int cnt  [6];
  int base [6];
  int lval [6];
  int lcyc [6];

  // 0 in, 1 up, 2 down, 3 open, 4 close, 5 frame_err
  initial for (int i = 0; i < 6; i++) begin
    cnt[i] = 0; base[i] = 0; lval[i] = 0; lcyc[i] = 0;
  end

  always @(posedge clk_50M) cyc <= cyc + 1;

  always @(negedge clk_50M) begin
    if (rst_n) begin
      if ($countones({req_in, req_up, req_down, open_button, close_button, frame_err}) > 1)
        multi = multi + 1;
      if (|req_in)      begin cnt[0]++; lval[0] = int'(req_in);   lcyc[0] = cyc; end
      if (|req_up)      begin cnt[1]++; lval[1] = int'(req_up);   lcyc[1] = cyc; end
      if (|req_down)    begin cnt[2]++; lval[2] = int'(req_down); lcyc[2] = cyc; end
      if (open_button)  begin cnt[3]++; lval[3] = 1;              lcyc[3] = cyc; end
      if (close_button) begin cnt[4]++; lval[4] = 1;              lcyc[4] = cyc; end
      if (frame_err)    begin cnt[5]++; lval[5] = 1;              lcyc[5] = cyc; end
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    for (int i = 0; i < 6; i++) base[i] = cnt[i];
  endtask

  function automatic int dl(input int i);
    return cnt[i] - base[i];
  endfunction

  function automatic int dtot();
    int s = 0;
    for (int i = 0; i < 6; i++) s += cnt[i] - base[i];
    return s;
  endfunction

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par);
    logic p;
    p = (~^b) ^ bad_par;
    return {1'b1, p, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_50M);
      ps2d = f[i];
      repeat (10) @(negedge clk_50M);
      ps2c = 1'b0;
      last_fall = cyc;
      repeat (30) @(negedge clk_50M);
      ps2c = 1'b1;
      repeat (20) @(negedge clk_50M);
    end
    ps2d = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(mk_frame(b, 1'b0), 11);
    repeat (20) @(negedge clk_50M);
  endtask

  initial begin
    repeat (5) @(negedge clk_50M);
    chk("reset_outputs", int'({req_in, req_up, req_down, open_button, close_button, frame_err}), 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk_50M);

    snap();
    send_byte(8'h26);
    chk("in_26_count", dl(0), 1);
    chk("in_26_value", lval[0], 'b000100);
    chk("in_26_latency", lcyc[0] - last_fall, LAT);
    chk("in_26_others", dtot() - dl(0), 0);

    snap();
    send_byte(8'h35);
    chk("up_top_ignored", dtot(), 0);
    snap();
    send_byte(8'h1C);
    chk("down_bottom_ignored", dtot(), 0);
    snap();
    send_byte(8'h1B);
    chk("down_1b_count", dl(2), 1);
    chk("down_1b_value", lval[2], 'b000010);
    chk("down_1b_others", dtot() - dl(2), 0);

    snap();
    send_byte(8'hF0);
    send_byte(8'h44);
    chk("break_44_silent", dtot(), 0);
    snap();
    send_byte(8'h44);
    chk("open_count", dl(3), 1);
    chk("open_others", dtot() - dl(3), 0);
    snap();
    send_byte(8'hE0);
    send_byte(8'h21);
    chk("ext_21_silent", dtot(), 0);

    snap();
    send_bits(mk_frame(8'h16, 1'b1), 11);
    repeat (20) @(negedge clk_50M);
    chk("badpar_err", dl(5), 1);
    chk("badpar_no_req", dl(0), 0);
    snap();
    send_byte(8'h16);
    chk("in_16_count", dl(0), 1);
    chk("in_16_value", lval[0], 'b000001);

    snap();
    send_bits(mk_frame(8'h21, 1'b0), 5);
    repeat (50200) @(negedge clk_50M);
    chk("timeout_err", dl(5), 1);
    chk("timeout_no_req", dtot() - dl(5), 0);
    snap();
    send_byte(8'h21);
    chk("close_after_tmo", dl(4), 1);
    chk("close_after_tmo_others", dtot() - dl(4), 0);

    snap();
    send_byte(8'h1E);
    send_byte(8'h1E);
    send_byte(8'h1E);
    send_byte(8'hF0);
    send_byte(8'h1E);
    send_byte(8'h1E);
    chk("typematic_count", dl(0), TYP_EXP);
    chk("typematic_value", lval[0], 'b000010);

    snap();
    send_bits(mk_frame(8'h26, 1'b0), 4);
    @(negedge clk_50M);
    rst_n = 1'b0;
    repeat (3) @(negedge clk_50M);
    chk("midreset_outputs", int'({req_in, req_up, req_down, open_button, close_button, frame_err}), 0);
    rst_n = 1'b1;
    repeat (100) @(negedge clk_50M);
    chk("midreset_silent", dtot(), 0);
    snap();
    send_byte(8'h26);
    chk("after_reset_in", dl(0), 1);
    chk("after_reset_value", lval[0], 'b000100);

    chk("onehot_violations", multi, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
